// File: rtl/kronos_if_fetch_if.sv
// Kronos IF-stage interface bundle.
// Groups the instruction bus, the execute-stage redirect and the IF/ID handshake that the
// fetch stage drives.
//   master : fetch stage side (drives instr_addr/instr_req, fetch/fetch_vld)
//   slave  : environment side (bus slave, execute redirect, decode consumer)
// Signals:
//   instr_addr[31:0], instr_req     fetch request, held stable until instr_ack
//   instr_ack, instr_data[31:0]     bus completion and fetched word
//   branch, branch_target[31:0]     one-cycle redirect strobe and its target
//   fetch (pipeIFID_t), fetch_vld   queue head {pc, ir} and its valid
//   fetch_rdy                       decode accepts the head
interface kronos_if_fetch_if;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        branch;
  logic [31:0] branch_target;
  pipeIFID_t   fetch;
  logic        fetch_vld;
  logic        fetch_rdy;

  modport master (
    output instr_addr,
    output instr_req,
    input  instr_ack,
    input  instr_data,
    input  branch,
    input  branch_target,
    output fetch,
    output fetch_vld,
    input  fetch_rdy
  );

  modport slave (
    input  instr_addr,
    input  instr_req,
    output instr_ack,
    output instr_data,
    output branch,
    output branch_target,
    input  fetch,
    input  fetch_vld,
    output fetch_rdy
  );

endinterface

// File: rtl/kronos_if_fetch.sv
// Kronos RV32I instruction fetch stage.
// Masters the instruction bus, buffers up to two fetched words in a small queue and presents
// the head {pc, ir} to decode over a valid/ready handshake. A redirect from execute flushes
// the queue; a request already in flight is allowed to complete and its data is discarded
// (FLUSH state) before fetch restarts at the latest target.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : kronos_if_fetch_if.master (instruction bus, redirect, IF/ID handshake)
// Parameters:
//   BOOT_ADDR : first fetch address after reset, word aligned
module kronos_if_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  kronos_if_fetch_if.master bus
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic [31:0] target_q, target_d;
  logic [1:0]  count_q, count_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [31:0] pc_mem_q [2];
  logic [31:0] ir_mem_q [2];

  logic        instr_req;
  logic        fetch_vld;
  logic        push;
  logic        pop;
  logic [31:0] branch_addr;

  assign branch_addr = {bus.branch_target[31:2], 2'b00};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        // A redirect with an unacknowledged request must wait for that request to finish.
        if (bus.branch && instr_req && !bus.instr_ack) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (bus.instr_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM outputs: request while flushing or while the queue has room
  always_comb begin
    instr_req = 1'b0;
    if (!rst) begin
      instr_req = (state_q == StFlush) || (count_q < 2'd2);
    end
  end

  assign fetch_vld = (count_q != 2'd0);
  assign push      = instr_req && bus.instr_ack && (state_q == StRun) && !bus.branch;
  assign pop       = fetch_vld && bus.fetch_rdy && !bus.branch;

  // Datapath next state
  always_comb begin
    pc_req_d = pc_req_q;
    target_d = target_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (bus.branch) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      // In FLUSH instr_req is always high, so this reduces to "ack this cycle".
      if (!instr_req || bus.instr_ack) begin
        pc_req_d = branch_addr;
      end else begin
        target_d = branch_addr;
      end
    end else if (state_q == StFlush) begin
      if (bus.instr_ack) begin
        pc_req_d = target_q;
      end
    end else begin
      if (push) begin
        pc_req_d = pc_req_q + 32'd4;
        wptr_d   = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_req_q <= BOOT_ADDR;
      target_q <= BOOT_ADDR;
      count_q  <= 2'd0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
    end else begin
      pc_req_q <= pc_req_d;
      target_q <= target_d;
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  // Queue storage needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wptr_q] <= pc_req_q;
      ir_mem_q[wptr_q] <= bus.instr_data;
    end
  end

  assign bus.instr_addr = pc_req_q;
  assign bus.instr_req  = instr_req;
  assign bus.fetch_vld  = fetch_vld;
  assign bus.fetch      = {pc_mem_q[rptr_q], ir_mem_q[rptr_q]};

endmodule

// File: tb/tb_kronos_if_fetch.sv
// Self-checking bench for kronos_if_fetch: directed scenarios plus a randomized run
// compared against a transaction-level queue model.
module tb_kronos_if_fetch;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] salt;
  int          n_checks;
  int          n_errors;

  kronos_if_fetch_if bus ();

  kronos_if_fetch #(
    .BOOT_ADDR(BOOT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Bus slave returns a word derived from the address so dropped/misplaced data is visible.
  assign bus.instr_data = bus.instr_addr ^ salt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.instr_ack     = 1'b0;
    bus.fetch_rdy     = 1'b0;
    bus.branch        = 1'b0;
    bus.branch_target = 32'h0;
    salt              = 32'hC0DE_0013;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    bus.instr_ack     = 1'b1;
    bus.fetch_rdy     = 1'b1;
    bus.branch        = 1'b0;
    bus.branch_target = 32'h0;
    salt              = 32'hC0DE_0013;
    tick();
    n_checks++;
    if (bus.instr_req !== 1'b0) begin
      n_errors++; $display("FAIL reset_req: got %b want 0", bus.instr_req);
    end
    n_checks++;
    if (bus.fetch_vld !== 1'b0) begin
      n_errors++; $display("FAIL reset_vld: got %b want 0", bus.fetch_vld);
    end
    tick();
    rst = 1'b0;
    bus.instr_ack = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_addr !== BOOT) begin
      n_errors++; $display("FAIL boot_addr: got %h want %h", bus.instr_addr, BOOT);
    end
    n_checks++;
    if (bus.instr_req !== 1'b1) begin
      n_errors++; $display("FAIL boot_req: got %b want 1", bus.instr_req);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    do_reset();
    bus.instr_ack = 1'b1;
    bus.fetch_rdy = 1'b1;
    #1;
    n_checks++;
    if (bus.fetch_vld !== 1'b0) begin
      n_errors++; $display("FAIL stream_vld0: got %b want 0", bus.fetch_vld);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      pc = BOOT + 32'(4 * (i - 1));
      n_checks++;
      if (bus.instr_addr !== BOOT + 32'(4 * i)) begin
        n_errors++;
        $display("FAIL stream_addr: got %h want %h", bus.instr_addr, BOOT + 32'(4 * i));
      end
      n_checks++;
      if (bus.fetch_vld !== 1'b1 || bus.fetch.pc !== pc || bus.fetch.ir !== (pc ^ salt)) begin
        n_errors++;
        $display("FAIL stream_head: got vld=%b pc=%h ir=%h want vld=1 pc=%h ir=%h",
                 bus.fetch_vld, bus.fetch.pc, bus.fetch.ir, pc, pc ^ salt);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    do_reset();
    bus.instr_ack = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus.instr_req !== 1'b0 || bus.instr_addr !== 32'h108 || bus.fetch_vld !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_full: got req=%b addr=%h vld=%b want req=0 addr=00000108 vld=1",
                 bus.instr_req, bus.instr_addr, bus.fetch_vld);
      end
      if (k == 0) tick();
    end
    bus.fetch_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.fetch_vld === 1'b1) got.push_back(bus.fetch.pc);
      tick();
    end
    n_checks++;
    if (got.size() < 3) begin
      n_errors++; $display("FAIL bp_count: got %0d words want at least 3", got.size());
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        n_checks++;
        if (got[k] !== BOOT + 32'(4 * k)) begin
          n_errors++; $display("FAIL bp_order: got %h want %h", got[k], BOOT + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_flush_pending();
    do_reset();
    bus.instr_ack = 1'b1;
    bus.fetch_rdy = 1'b1;
    tick();
    bus.instr_ack     = 1'b0;
    bus.branch        = 1'b1;
    bus.branch_target = 32'h2000;
    tick();
    bus.branch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.instr_ack = 1'b1;
      #1;
      n_checks++;
      if (bus.instr_addr !== 32'h104 || bus.instr_req !== 1'b1 || bus.fetch_vld !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_hold: got addr=%h req=%b vld=%b want addr=00000104 req=1 vld=0",
                 bus.instr_addr, bus.instr_req, bus.fetch_vld);
      end
      tick();
    end
    bus.instr_ack = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_addr !== 32'h2000 || bus.instr_req !== 1'b1 || bus.fetch_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_restart: got addr=%h req=%b vld=%b want addr=00002000 req=1 vld=0",
               bus.instr_addr, bus.instr_req, bus.fetch_vld);
    end
    bus.instr_ack = 1'b1;
    tick();
    n_checks++;
    if (bus.fetch_vld !== 1'b1 || bus.fetch.pc !== 32'h2000) begin
      n_errors++;
      $display("FAIL flush_head: got vld=%b pc=%h want vld=1 pc=00002000",
               bus.fetch_vld, bus.fetch.pc);
    end
  endtask

  task automatic test_branch_with_ack();
    do_reset();
    bus.instr_ack = 1'b1;
    bus.fetch_rdy = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.instr_addr !== 32'h108) begin
      n_errors++; $display("FAIL bwa_pre: got %h want 00000108", bus.instr_addr);
    end
    bus.branch        = 1'b1;
    bus.branch_target = 32'h2002;
    tick();
    bus.branch = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_addr !== 32'h2000 || bus.fetch_vld !== 1'b0 || bus.instr_req !== 1'b1) begin
      n_errors++;
      $display("FAIL bwa_redirect: got addr=%h vld=%b req=%b want addr=00002000 vld=0 req=1",
               bus.instr_addr, bus.fetch_vld, bus.instr_req);
    end
    tick();
    n_checks++;
    if (bus.fetch_vld !== 1'b1 || bus.fetch.pc !== 32'h2000) begin
      n_errors++;
      $display("FAIL bwa_head: got vld=%b pc=%h want vld=1 pc=00002000",
               bus.fetch_vld, bus.fetch.pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.instr_ack = 1'b1;
    bus.fetch_rdy = 1'b1;
    tick();
    bus.instr_ack     = 1'b0;
    bus.branch        = 1'b1;
    bus.branch_target = 32'h3000;
    tick();
    bus.branch_target = 32'h4000;
    #1;
    n_checks++;
    if (bus.instr_addr !== 32'h104 || bus.fetch_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_hold: got addr=%h vld=%b want addr=00000104 vld=0",
               bus.instr_addr, bus.fetch_vld);
    end
    tick();
    bus.branch    = 1'b0;
    bus.instr_ack = 1'b1;
    tick();
    bus.instr_ack = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_addr !== 32'h4000 || bus.instr_req !== 1'b1 || bus.fetch_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_target: got addr=%h req=%b vld=%b want addr=00004000 req=1 vld=0",
               bus.instr_addr, bus.instr_req, bus.fetch_vld);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.instr_ack = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.fetch_vld !== 1'b1 || bus.instr_req !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_full: got vld=%b req=%b want vld=1 req=0", bus.fetch_vld, bus.instr_req);
    end
    bus.instr_ack = 1'b0;
    bus.fetch_rdy = 1'b1;
    tick();
    n_checks++;
    if (bus.instr_req !== 1'b1 || bus.instr_addr !== 32'h108) begin
      n_errors++;
      $display("FAIL mid_pending: got req=%b addr=%h want req=1 addr=00000108",
               bus.instr_req, bus.instr_addr);
    end
    rst           = 1'b1;
    bus.instr_ack = 1'b1;
    #1;
    n_checks++;
    if (bus.instr_req !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst_req: got %b want 0", bus.instr_req);
    end
    tick();
    n_checks++;
    if (bus.instr_req !== 1'b0 || bus.fetch_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_rst_out: got req=%b vld=%b want req=0 vld=0",
               bus.instr_req, bus.fetch_vld);
    end
    tick();
    rst           = 1'b0;
    bus.instr_ack = 1'b0;
    #1;
    n_checks++;
    if (bus.instr_addr !== BOOT || bus.instr_req !== 1'b1 || bus.fetch_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_boot: got addr=%h req=%b vld=%b want addr=%h req=1 vld=0",
               bus.instr_addr, bus.instr_req, bus.fetch_vld, BOOT);
    end
    bus.instr_ack = 1'b1;
    tick();
    n_checks++;
    if (bus.fetch_vld !== 1'b1 || bus.fetch.pc !== BOOT) begin
      n_errors++;
      $display("FAIL mid_head: got vld=%b pc=%h want vld=1 pc=%h",
               bus.fetch_vld, bus.fetch.pc, BOOT);
    end
  endtask

  // Reference: a queue of {pc, ir}, the next fetch address, and whether an abandoned
  // request is still outstanding (with the target to resume at).
  task automatic test_random();
    logic [63:0] mq [$];
    logic [31:0] mpc;
    logic [31:0] mtgt;
    logic [31:0] tg;
    logic [31:0] head_pc;
    logic [31:0] head_ir;
    bit          draining;
    bit          exp_req;
    bit          ack;
    bit          rs;
    do_reset();
    mpc      = BOOT;
    mtgt     = BOOT;
    draining = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rs                = ($urandom_range(0, 299) == 0);
      rst               = rs;
      bus.instr_ack     = ($urandom_range(0, 3) != 0);
      bus.fetch_rdy     = ($urandom_range(0, 3) != 0);
      bus.branch        = ($urandom_range(0, 11) == 0);
      tg                = $urandom;
      bus.branch_target = tg;
      salt              = $urandom;
      #1;
      exp_req = !rs && (draining || mq.size() < 2);
      n_checks++;
      if (bus.instr_req !== exp_req || bus.instr_addr !== mpc) begin
        n_errors++;
        $display("FAIL rnd_req: cyc %0d got req=%b addr=%h want req=%b addr=%h",
                 cyc, bus.instr_req, bus.instr_addr, exp_req, mpc);
      end
      n_checks++;
      if (bus.fetch_vld !== (mq.size() != 0)) begin
        n_errors++;
        $display("FAIL rnd_vld: cyc %0d got %b want %b", cyc, bus.fetch_vld, mq.size() != 0);
      end else if (mq.size() != 0) begin
        head_pc = mq[0][63:32];
        head_ir = mq[0][31:0];
        n_checks++;
        if (bus.fetch.pc !== head_pc || bus.fetch.ir !== head_ir) begin
          n_errors++;
          $display("FAIL rnd_head: cyc %0d got pc=%h ir=%h want pc=%h ir=%h",
                   cyc, bus.fetch.pc, bus.fetch.ir, head_pc, head_ir);
        end
      end
      if (rs) begin
        mq.delete();
        mpc      = BOOT;
        draining = 1'b0;
      end else begin
        ack = exp_req && bus.instr_ack;
        if (bus.branch) begin
          mq.delete();
          if (!exp_req || ack) begin
            mpc      = tg & 32'hFFFF_FFFC;
            draining = 1'b0;
          end else begin
            mtgt     = tg & 32'hFFFF_FFFC;
            draining = 1'b1;
          end
        end else if (draining) begin
          if (ack) begin
            mpc      = mtgt;
            draining = 1'b0;
          end
        end else begin
          if (mq.size() != 0 && bus.fetch_rdy) void'(mq.pop_front());
          if (ack) begin
            mq.push_back({mpc, mpc ^ salt});
            mpc = mpc + 32'd4;
          end
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_pending();
    test_branch_with_ack();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
